// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: captures one word access, runs req/gnt + rvalid, returns data/ack.
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN (counter width TIMEOUT_W).
module lsu_bus_ctrl #(
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_req_i,
    input  logic        ex_we_i,
    input  logic [31:0] ex_addr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic [3:0]  ex_wmask_i,
    output logic [31:0] ex_rdata_o,
    output logic        ex_ack_o,
    output logic        ex_err_o,
    output logic        hold_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic        ex_ack_q, ex_ack_d;
    logic        ex_err_q, ex_err_d;
    logic [31:0] ex_rdata_q, ex_rdata_d;
    logic        timeout_c;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^ex_addr_i[1:0];

`ifdef LSU_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    // Watchdog: zeroed while idle so it starts at 0 on REQ entry, counts through REQ/WAIT.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if ((state_q == ST_REQ) || (state_q == ST_WAIT)) begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end
    end

    assign timeout_c = ((state_q == ST_REQ) || (state_q == ST_WAIT)) && (cnt_q == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_w;

    assign unused_timeout_w = ^32'(TIMEOUT_W);
    assign timeout_c        = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        ex_ack_d    = 1'b0;
        ex_err_d    = 1'b0;
        ex_rdata_d  = ex_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (ex_req_i) begin
                    state_d     = ST_REQ;
                    bus_req_d   = 1'b1;
                    bus_we_d    = ex_we_i;
                    bus_addr_d  = {ex_addr_i[31:2], 2'b00};
                    bus_wdata_d = ex_we_i ? ex_wdata_i : 32'h0;
                    bus_be_d    = ex_we_i ? ex_wmask_i : 4'b1111;
                end
            end
            ST_REQ: begin
                if (timeout_c) begin
                    state_d    = ST_DONE;
                    bus_req_d  = 1'b0;
                    ex_ack_d   = 1'b1;
                    ex_err_d   = 1'b1;
                    ex_rdata_d = 32'h0;
                end else if (bus_gnt_i) begin
                    state_d   = ST_WAIT;
                    bus_req_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (timeout_c) begin
                    state_d    = ST_DONE;
                    ex_ack_d   = 1'b1;
                    ex_err_d   = 1'b1;
                    ex_rdata_d = 32'h0;
                end else if (bus_rvalid_i) begin
                    state_d    = ST_DONE;
                    ex_ack_d   = 1'b1;
                    ex_err_d   = bus_err_i;
                    ex_rdata_d = (bus_we_q || bus_err_i) ? 32'h0 : bus_rdata_i;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            bus_be_q    <= 4'b0000;
            ex_ack_q    <= 1'b0;
            ex_err_q    <= 1'b0;
            ex_rdata_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            ex_ack_q    <= ex_ack_d;
            ex_err_q    <= ex_err_d;
            ex_rdata_q  <= ex_rdata_d;
        end
    end

    // Stall is combinational so the pipeline freezes in the same cycle the request appears.
    assign hold_o = ((state_q == ST_IDLE) && ex_req_i) || (state_q == ST_REQ) || (state_q == ST_WAIT);

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_be_o    = bus_be_q;
    assign ex_ack_o    = ex_ack_q;
    assign ex_err_o    = ex_err_q;
    assign ex_rdata_o  = ex_rdata_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench for lsu_bus_ctrl: scoreboard of expected {rdata, err} per access.
// Timeout scenario runs only when LSU_TIMEOUT_EN is defined.
module tb_lsu_bus_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_req_i;
    logic        ex_we_i;
    logic [31:0] ex_addr_i;
    logic [31:0] ex_wdata_i;
    logic [3:0]  ex_wmask_i;
    logic [31:0] ex_rdata_o;
    logic        ex_ack_o;
    logic        ex_err_o;
    logic        hold_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_i;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    lsu_bus_ctrl #(.TIMEOUT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_req_i    (ex_req_i),
        .ex_we_i     (ex_we_i),
        .ex_addr_i   (ex_addr_i),
        .ex_wdata_i  (ex_wdata_i),
        .ex_wmask_i  (ex_wmask_i),
        .ex_rdata_o  (ex_rdata_o),
        .ex_ack_o    (ex_ack_o),
        .ex_err_o    (ex_err_o),
        .hold_o      (hold_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_be_o    (bus_be_o),
        .bus_gnt_i   (bus_gnt_i),
        .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i (bus_rdata_i),
        .bus_err_i   (bus_err_i)
    );

    // Drive point: just after the active edge. Sample point: falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic bus_idle();
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = 32'h0;
        bus_err_i    = 1'b0;
    endtask

    function automatic logic [104:0] all_outs();
        return {ex_rdata_o, ex_ack_o, ex_err_o, hold_o, bus_req_o, bus_we_o,
                bus_addr_o, bus_wdata_o, bus_be_o};
    endfunction

    task automatic test_reset();
        rst_n      = 1'b0;
        ex_req_i   = 1'b0;
        ex_we_i    = 1'b0;
        ex_addr_i  = 32'h0;
        ex_wdata_i = 32'h0;
        ex_wmask_i = 4'h0;
        bus_idle();
        repeat (3) cyc();
        smp();
        tests_run++; if (all_outs() !== 105'h0) begin tests_failed++; $display("FAIL reset_outs: got %h want 0", all_outs()); end
        cyc();
        rst_n = 1'b1;
        smp();
        tests_run++; if (all_outs() !== 105'h0) begin tests_failed++; $display("FAIL reset_release_outs: got %h want 0", all_outs()); end
    endtask

    task automatic test_load();
        exp_t e;
        cyc();
        ex_req_i = 1'b1; ex_we_i = 1'b0; ex_addr_i = 32'h0000_1006;
        ex_wdata_i = 32'hFFFF_FFFF; ex_wmask_i = 4'b0011;
        sb.push_back({32'hA5A5_1234, 1'b0});
        smp();
        tests_run++; if (hold_o !== 1'b1) begin tests_failed++; $display("FAIL load_hold_c0: got %b want 1", hold_o); end
        tests_run++; if (bus_req_o !== 1'b0) begin tests_failed++; $display("FAIL load_req_c0: got %b want 0", bus_req_o); end
        cyc();
        bus_gnt_i = 1'b1;
        smp();
        tests_run++; if (bus_req_o !== 1'b1) begin tests_failed++; $display("FAIL load_req_c1: got %b want 1", bus_req_o); end
        tests_run++; if ({bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o} !== {1'b0, 32'h0000_1004, 32'h0, 4'b1111})
            begin tests_failed++; $display("FAIL load_fields: got we=%b addr=%h wdata=%h be=%b want we=0 addr=00001004 wdata=0 be=1111", bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o); end
        cyc();
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hA5A5_1234;
        smp();
        tests_run++; if ({bus_req_o, hold_o, ex_ack_o} !== 3'b010) begin tests_failed++; $display("FAIL load_wait_c2: got req/hold/ack=%b want 010", {bus_req_o, hold_o, ex_ack_o}); end
        cyc();
        bus_idle();
        smp();
        tests_run++; if ({ex_ack_o, hold_o} !== 2'b10) begin tests_failed++; $display("FAIL load_ack_c3: got ack/hold=%b want 10", {ex_ack_o, hold_o}); end
        if (sb.size() == 0) begin
            tests_run++; tests_failed++; $display("FAIL load_sb: got empty scoreboard want entry");
        end else begin
            e = sb.pop_front();
            tests_run++; if ({ex_rdata_o, ex_err_o} !== {e.rdata, e.err}) begin tests_failed++; $display("FAIL load_data: got %h/%b want %h/%b", ex_rdata_o, ex_err_o, e.rdata, e.err); end
        end
        cyc();
        ex_req_i = 1'b0;
        smp();
        tests_run++; if ({ex_ack_o, ex_err_o, ex_rdata_o} !== {1'b0, 1'b0, 32'hA5A5_1234}) begin tests_failed++; $display("FAIL load_after_ack: got ack=%b err=%b rdata=%h want 0 0 a5a51234", ex_ack_o, ex_err_o, ex_rdata_o); end
    endtask

    task automatic test_store();
        exp_t e;
        cyc();
        ex_req_i = 1'b1; ex_we_i = 1'b1; ex_addr_i = 32'h0000_2000;
        ex_wdata_i = 32'h0000_00EF; ex_wmask_i = 4'b0001;
        sb.push_back({32'h0, 1'b0});
        for (int i = 1; i <= 5; i++) begin
            cyc();
            bus_gnt_i    = (i == 5);
            bus_rvalid_i = (i == 3);
            bus_rdata_i  = (i == 3) ? 32'hBAD0_BAD0 : 32'h0;
            smp();
            tests_run++; if ({bus_req_o, hold_o, ex_ack_o} !== 3'b110) begin tests_failed++; $display("FAIL store_req_c%0d: got req/hold/ack=%b want 110", i, {bus_req_o, hold_o, ex_ack_o}); end
            tests_run++; if ({bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o} !== {1'b1, 32'h0000_2000, 32'h0000_00EF, 4'b0001})
                begin tests_failed++; $display("FAIL store_fields_c%0d: got we=%b addr=%h wdata=%h be=%b", i, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o); end
        end
        cyc();
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEAD_BEEF;
        smp();
        tests_run++; if ({bus_req_o, hold_o, ex_ack_o} !== 3'b010) begin tests_failed++; $display("FAIL store_wait: got req/hold/ack=%b want 010", {bus_req_o, hold_o, ex_ack_o}); end
        cyc();
        bus_idle();
        smp();
        tests_run++; if ({ex_ack_o, hold_o} !== 2'b10) begin tests_failed++; $display("FAIL store_ack: got ack/hold=%b want 10", {ex_ack_o, hold_o}); end
        if (sb.size() == 0) begin
            tests_run++; tests_failed++; $display("FAIL store_sb: got empty scoreboard want entry");
        end else begin
            e = sb.pop_front();
            tests_run++; if ({ex_rdata_o, ex_err_o} !== {e.rdata, e.err}) begin tests_failed++; $display("FAIL store_data: got %h/%b want %h/%b", ex_rdata_o, ex_err_o, e.rdata, e.err); end
        end
        cyc();
        ex_req_i = 1'b0;
    endtask

    task automatic test_error();
        exp_t e;
        cyc();
        ex_req_i = 1'b1; ex_we_i = 1'b0; ex_addr_i = 32'h0000_3000;
        sb.push_back({32'h0, 1'b1});
        cyc();
        bus_gnt_i = 1'b1;
        cyc();
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_err_i = 1'b1; bus_rdata_i = 32'h1234_5678;
        cyc();
        bus_idle();
        smp();
        tests_run++; if (ex_ack_o !== 1'b1) begin tests_failed++; $display("FAIL err_ack: got %b want 1", ex_ack_o); end
        if (sb.size() == 0) begin
            tests_run++; tests_failed++; $display("FAIL err_sb: got empty scoreboard want entry");
        end else begin
            e = sb.pop_front();
            tests_run++; if ({ex_rdata_o, ex_err_o} !== {e.rdata, e.err}) begin tests_failed++; $display("FAIL err_data: got %h/%b want %h/%b", ex_rdata_o, ex_err_o, e.rdata, e.err); end
        end
        // Follow-up load right after the errored one.
        cyc();
        ex_addr_i = 32'h0000_3008;
        sb.push_back({32'h0BAD_F00D, 1'b0});
        smp();
        tests_run++; if ({ex_ack_o, ex_err_o, hold_o} !== 3'b001) begin tests_failed++; $display("FAIL err_next_c0: got ack/err/hold=%b want 001", {ex_ack_o, ex_err_o, hold_o}); end
        cyc();
        bus_gnt_i = 1'b1;
        smp();
        tests_run++; if ({bus_req_o, bus_addr_o} !== {1'b1, 32'h0000_3008}) begin tests_failed++; $display("FAIL err_next_req: got req=%b addr=%h want 1 00003008", bus_req_o, bus_addr_o); end
        cyc();
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0BAD_F00D;
        cyc();
        bus_idle();
        smp();
        tests_run++; if (ex_ack_o !== 1'b1) begin tests_failed++; $display("FAIL err_next_ack: got %b want 1", ex_ack_o); end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            tests_run++; if ({ex_rdata_o, ex_err_o} !== {e.rdata, e.err}) begin tests_failed++; $display("FAIL err_next_data: got %h/%b want %h/%b", ex_rdata_o, ex_err_o, e.rdata, e.err); end
        end
        cyc();
        ex_req_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   acks = 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            ex_req_i  = 1'b1; ex_we_i = 1'b0;
            ex_addr_i = 32'h0000_0500 + 32'(k) * 32'd16 + 32'(k);
            sb.push_back({32'hC0DE_0000 + 32'(k), 1'b0});
            smp();
            tests_run++; if ({bus_req_o, hold_o} !== 2'b01) begin tests_failed++; $display("FAIL b2b_c0_k%0d: got req/hold=%b want 01", k, {bus_req_o, hold_o}); end
            cyc();
            bus_gnt_i = 1'b1;
            smp();
            tests_run++; if ({bus_req_o, bus_addr_o} !== {1'b1, 32'h0000_0500 + 32'(k) * 32'd16})
                begin tests_failed++; $display("FAIL b2b_req_k%0d: got req=%b addr=%h want 1 %h", k, bus_req_o, bus_addr_o, 32'h0000_0500 + 32'(k) * 32'd16); end
            cyc();
            bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hC0DE_0000 + 32'(k);
            cyc();
            bus_idle();
            smp();
            if (ex_ack_o === 1'b1) acks++;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                tests_run++; if ({ex_ack_o, ex_rdata_o, ex_err_o} !== {1'b1, e.rdata, e.err}) begin tests_failed++; $display("FAIL b2b_ack_k%0d: got ack=%b %h/%b want 1 %h/%b", k, ex_ack_o, ex_rdata_o, ex_err_o, e.rdata, e.err); end
            end
        end
        cyc();
        ex_req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp();
            if (ex_ack_o === 1'b1) acks++;
            tests_run++; if ({bus_req_o, ex_ack_o, hold_o} !== 3'b000) begin tests_failed++; $display("FAIL b2b_quiet_%0d: got req/ack/hold=%b want 000", i, {bus_req_o, ex_ack_o, hold_o}); end
            cyc();
        end
        tests_run++; if (acks !== 3) begin tests_failed++; $display("FAIL b2b_ack_count: got %0d want 3", acks); end
    endtask

    task automatic test_reset_mid();
        // Abort while the request is still being presented.
        cyc();
        ex_req_i = 1'b1; ex_we_i = 1'b0; ex_addr_i = 32'h0000_6000;
        cyc();
        smp();
        tests_run++; if (bus_req_o !== 1'b1) begin tests_failed++; $display("FAIL rstreq_pre: got %b want 1", bus_req_o); end
        #2;
        rst_n = 1'b0; ex_req_i = 1'b0;
        #1;
        tests_run++; if (all_outs() !== 105'h0) begin tests_failed++; $display("FAIL rstreq_async: got %h want 0", all_outs()); end
        cyc();
        cyc();
        rst_n = 1'b1;
        // Abort while waiting for the response; the late response must not ack.
        cyc();
        ex_req_i = 1'b1; ex_addr_i = 32'h0000_7000;
        cyc();
        bus_gnt_i = 1'b1;
        cyc();
        bus_gnt_i = 1'b0;
        smp();
        tests_run++; if ({bus_req_o, hold_o} !== 2'b01) begin tests_failed++; $display("FAIL rstwait_pre: got req/hold=%b want 01", {bus_req_o, hold_o}); end
        #2;
        rst_n = 1'b0; ex_req_i = 1'b0;
        #1;
        tests_run++; if (all_outs() !== 105'h0) begin tests_failed++; $display("FAIL rstwait_async: got %h want 0", all_outs()); end
        cyc();
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h7777_7777;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            smp();
            tests_run++; if ({ex_ack_o, bus_req_o, ex_rdata_o} !== {1'b0, 1'b0, 32'h0}) begin tests_failed++; $display("FAIL rstwait_late_%0d: got ack=%b req=%b rdata=%h want 0 0 0", i, ex_ack_o, bus_req_o, ex_rdata_o); end
            cyc();
            bus_idle();
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        cyc();
        ex_req_i = 1'b1; ex_we_i = 1'b0; ex_addr_i = 32'h0000_8000;
        sb.push_back({32'h0, 1'b1});
        for (int i = 1; i <= 16; i++) begin
            cyc();
            smp();
            tests_run++; if ({bus_req_o, ex_ack_o, hold_o} !== 3'b101) begin tests_failed++; $display("FAIL to_wait_c%0d: got req/ack/hold=%b want 101", i, {bus_req_o, ex_ack_o, hold_o}); end
        end
        cyc();
        smp();
        tests_run++; if ({ex_ack_o, bus_req_o} !== 2'b10) begin tests_failed++; $display("FAIL to_ack: got ack/req=%b want 10", {ex_ack_o, bus_req_o}); end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            tests_run++; if ({ex_rdata_o, ex_err_o} !== {e.rdata, e.err}) begin tests_failed++; $display("FAIL to_data: got %h/%b want %h/%b", ex_rdata_o, ex_err_o, e.rdata, e.err); end
        end
        cyc();
        ex_req_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h5555_5555;
        smp();
        tests_run++; if ({ex_ack_o, bus_req_o} !== 2'b00) begin tests_failed++; $display("FAIL to_late_c0: got ack/req=%b want 00", {ex_ack_o, bus_req_o}); end
        cyc();
        bus_idle();
        smp();
        tests_run++; if ({ex_ack_o, ex_err_o, bus_req_o} !== 3'b000) begin tests_failed++; $display("FAIL to_late_c1: got ack/err/req=%b want 000", {ex_ack_o, ex_err_o, bus_req_o}); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_load();
        test_store();
        test_error();
        test_back_to_back();
        test_reset_mid();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        tests_run++; if (sb.size() != 0) begin tests_failed++; $display("FAIL sb_empty: got %0d entries want 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
